// File: rtl/data_path_pkg.sv
// Shared constants for the Mini SRC datapath: data width and 5-bit ALU opcodes.
package data_path_pkg;
  localparam int DATA_W = 32;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_NOT  = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b00101;
  localparam logic [4:0] OP_DIV  = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b01100;
endpackage

// File: rtl/data_path_if.sv
// Control/observation bundle between the control unit (master) and the datapath (slave).
interface data_path_if;
  import data_path_pkg::*;
  logic e_R1, e_R2, e_R3, e_R4, e_R5;
  logic e_PC, e_IR, e_MAR, e_MDR, e_Y, e_Z, e_HI, e_LO;
  logic s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5;
  logic w_IncPC, w_read, e_alu;
  logic [DATA_W-1:0] w_Mdatain;
  logic [4:0]        opcode;
  logic [DATA_W-1:0] o_bus, o_IR, o_MAR;

  modport master (
    output e_R1, e_R2, e_R3, e_R4, e_R5, e_PC, e_IR, e_MAR, e_MDR, e_Y, e_Z, e_HI, e_LO,
           s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5, w_IncPC, w_read, e_alu,
           w_Mdatain, opcode,
    input  o_bus, o_IR, o_MAR
  );

  modport slave (
    input  e_R1, e_R2, e_R3, e_R4, e_R5, e_PC, e_IR, e_MAR, e_MDR, e_Y, e_Z, e_HI, e_LO,
           s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5, w_IncPC, w_read, e_alu,
           w_Mdatain, opcode,
    output o_bus, o_IR, o_MAR
  );
endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU, A = Y, B = bus, 64-bit result.
// mul/div exist only when DATAPATH_MULDIV_EN is defined; otherwise those opcodes yield 0.
module data_path_alu
  import data_path_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [4:0]          opcode,
  input  logic                e_alu,
  input  logic                w_IncPC,
  output logic [2*DATA_W-1:0] r
);
  logic [4:0]          sh;
  logic [2*DATA_W-1:0] rol_t, ror_t;
  logic [DATA_W-1:0]   shra_t;

  assign sh     = b[4:0];
  // Rotates via a doubled copy of A so a zero amount needs no special case.
  assign rol_t  = {a, a} << sh;
  assign ror_t  = {a, a} >> sh;
  assign shra_t = $signed(a) >>> sh;

`ifdef DATAPATH_MULDIV_EN
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          quo, rem;
  logic                       b_zero;

  assign prod   = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign b_zero = (b == '0);
  assign quo    = b_zero ? '1 : DATA_W'($signed(a) / $signed(b));
  assign rem    = b_zero ? a  : DATA_W'($signed(a) % $signed(b));
`endif

  always_comb begin
    r = '0;
    if (w_IncPC) begin
      r = {{DATA_W{1'b0}}, b + 1'b1};
    end else if (e_alu) begin
      case (opcode)
        OP_ADD:  r[DATA_W-1:0] = a + b;
        OP_SUB:  r[DATA_W-1:0] = a - b;
        OP_AND:  r[DATA_W-1:0] = a & b;
        OP_OR:   r[DATA_W-1:0] = a | b;
        OP_NOT:  r[DATA_W-1:0] = ~b;
`ifdef DATAPATH_MULDIV_EN
        OP_MUL:  r = prod;
        OP_DIV:  r = {rem, quo};
`endif
        OP_ROL:  r[DATA_W-1:0] = rol_t[2*DATA_W-1:DATA_W];
        OP_ROR:  r[DATA_W-1:0] = ror_t[DATA_W-1:0];
        OP_SHR:  r[DATA_W-1:0] = a >> sh;
        OP_SHRA: r[DATA_W-1:0] = shra_t;
        OP_SHL:  r[DATA_W-1:0] = a << sh;
        OP_NEG:  r[DATA_W-1:0] = '0 - b;
        default: r = '0;
      endcase
    end
  end
endmodule

// File: rtl/data_path.sv
// Mini SRC single-bus datapath: registers, priority bus mux and the ALU.
// Optional mul/div in the ALU is enabled with DATAPATH_MULDIV_EN.
module data_path
  import data_path_pkg::*;
(
  input  logic      w_clock,
  input  logic      w_clear,
  data_path_if.slave dp
);
  logic [DATA_W-1:0]   r1, r2, r3, r4, r5;
  logic [DATA_W-1:0]   pc, ir, mar, mdr, y, hi, lo;
  logic [2*DATA_W-1:0] z, alu_r;
  logic [DATA_W-1:0]   bus;

  // Fixed priority: MDR wins over Zlow, and so on down to R5.
  always_comb begin
    bus = '0;
    if      (dp.s_MDR)  bus = mdr;
    else if (dp.s_Zlow) bus = z[DATA_W-1:0];
    else if (dp.s_PC)   bus = pc;
    else if (dp.s_R2)   bus = r2;
    else if (dp.s_R3)   bus = r3;
    else if (dp.s_R4)   bus = r4;
    else if (dp.s_R5)   bus = r5;
  end

  data_path_alu u_alu (
    .a       (y),
    .b       (bus),
    .opcode  (dp.opcode),
    .e_alu   (dp.e_alu),
    .w_IncPC (dp.w_IncPC),
    .r       (alu_r)
  );

  always_ff @(posedge w_clock) begin
    if (w_clear) begin
      r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0; r5 <= '0;
      pc <= '0; ir <= '0; mar <= '0; mdr <= '0; y <= '0;
      hi <= '0; lo <= '0; z <= '0;
    end else begin
      if (dp.e_R1)  r1  <= bus;
      if (dp.e_R2)  r2  <= bus;
      if (dp.e_R3)  r3  <= bus;
      if (dp.e_R4)  r4  <= bus;
      if (dp.e_R5)  r5  <= bus;
      if (dp.e_PC)  pc  <= bus;
      if (dp.e_IR)  ir  <= bus;
      if (dp.e_MAR) mar <= bus;
      if (dp.e_MDR) mdr <= dp.w_read ? dp.w_Mdatain : bus;
      if (dp.e_Y)   y   <= bus;
      if (dp.e_HI)  hi  <= bus;
      if (dp.e_LO)  lo  <= bus;
      if (dp.e_Z)   z   <= alu_r;
    end
  end

  assign dp.o_bus = bus;
  assign dp.o_IR  = ir;
  assign dp.o_MAR = mar;
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: MDR loads, fetch, OR, arithmetic/shift ops, div-by-zero, reset.
module tb_data_path;
  import data_path_pkg::*;

`ifdef DATAPATH_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   passed = 0;
  int   total  = 0;

  data_path_if dp ();

  data_path dut (
    .w_clock (clk),
    .w_clear (clr),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic idle();
    dp.e_R1 = 0; dp.e_R2 = 0; dp.e_R3 = 0; dp.e_R4 = 0; dp.e_R5 = 0;
    dp.e_PC = 0; dp.e_IR = 0; dp.e_MAR = 0; dp.e_MDR = 0; dp.e_Y = 0;
    dp.e_Z = 0; dp.e_HI = 0; dp.e_LO = 0;
    dp.s_PC = 0; dp.s_Zlow = 0; dp.s_MDR = 0; dp.s_R2 = 0; dp.s_R3 = 0;
    dp.s_R4 = 0; dp.s_R5 = 0;
    dp.w_IncPC = 0; dp.w_read = 0; dp.e_alu = 0;
    dp.w_Mdatain = '0; dp.opcode = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic mdr_load(input logic [31:0] v);
    dp.w_Mdatain = v; dp.w_read = 1; dp.e_MDR = 1;
    tick();
  endtask

  // Y <= R4, then run opcode with R5 on the bus into Z.
  task automatic alu_r4_r5(input logic [4:0] op);
    dp.s_R4 = 1; dp.e_Y = 1; tick();
    dp.s_R5 = 1; dp.opcode = op; dp.e_alu = 1; dp.e_Z = 1; tick();
  endtask

  initial begin
    idle();
    tick();
    chk("reset_bus", {32'b0, dp.o_bus}, 64'h0);
    chk("reset_ir",  {32'b0, dp.o_IR},  64'h0);
    chk("reset_mar", {32'b0, dp.o_MAR}, 64'h0);
    chk("reset_z",   dut.z,             64'h0);
    clr = 0;

    // Register loads via MDR
    mdr_load(32'hB7); dp.s_MDR = 1; dp.e_R2 = 1; tick();
    mdr_load(32'hA6); dp.s_MDR = 1; dp.e_R3 = 1; tick();
    mdr_load(32'h18); dp.s_MDR = 1; dp.e_R1 = 1; tick();
    dp.s_R2 = 1; #1; chk("r2_load", {32'b0, dp.o_bus}, 64'hB7); idle();
    dp.s_R3 = 1; #1; chk("r3_load", {32'b0, dp.o_bus}, 64'hA6); idle();
    chk("r1_load", {32'b0, dut.r1}, 64'h18);

    // Bus priority: MDR beats R2
    dp.s_MDR = 1; dp.s_R2 = 1; #1; chk("bus_prio", {32'b0, dp.o_bus}, 64'h18); idle();

    // Fetch T0..T2
    dp.s_PC = 1; dp.e_MAR = 1; dp.w_IncPC = 1; dp.e_Z = 1; tick();
    chk("t0_mar", {32'b0, dp.o_MAR}, 64'h0);
    dp.s_Zlow = 1; #1; chk("t0_zlow", {32'b0, dp.o_bus}, 64'h1); idle();
    dp.s_Zlow = 1; dp.e_PC = 1; dp.w_read = 1; dp.e_MDR = 1; dp.w_Mdatain = 32'h2891_8000; tick();
    dp.s_PC = 1; #1; chk("t1_pc", {32'b0, dp.o_bus}, 64'h1); idle();
    dp.s_MDR = 1; #1; chk("t1_mdr", {32'b0, dp.o_bus}, 64'h2891_8000); idle();
    dp.s_MDR = 1; dp.e_IR = 1; tick();
    chk("t2_ir", {32'b0, dp.o_IR}, 64'h2891_8000);

    // OR T3..T5
    dp.s_R2 = 1; dp.e_Y = 1; tick();
    chk("t3_y", {32'b0, dut.y}, 64'hB7);
    dp.s_R3 = 1; dp.opcode = OP_OR; dp.e_alu = 1; dp.e_Z = 1; tick();
    dp.s_Zlow = 1; #1; chk("t4_or", {32'b0, dp.o_bus}, 64'hB7); idle();
    dp.s_Zlow = 1; dp.e_R1 = 1; dp.e_LO = 1; tick();
    chk("t5_r1", {32'b0, dut.r1}, 64'hB7);
    chk("t5_lo", {32'b0, dut.lo}, 64'hB7);

    // Same-cycle source and load of R2 keeps its value
    dp.s_R2 = 1; dp.e_R2 = 1; tick();
    dp.s_R2 = 1; #1; chk("r2_self", {32'b0, dp.o_bus}, 64'hB7); idle();

    // mul / div with Y = -2, B = 3
    mdr_load(32'hFFFF_FFFE); dp.s_MDR = 1; dp.e_R4 = 1; tick();
    mdr_load(32'h3);         dp.s_MDR = 1; dp.e_R5 = 1; tick();
    alu_r4_r5(OP_MUL);
    chk("mul", dut.z, MULDIV ? 64'hFFFF_FFFF_FFFF_FFFA : 64'h0);
    alu_r4_r5(OP_DIV);
    chk("div", dut.z, MULDIV ? 64'hFFFF_FFFE_0000_0000 : 64'h0);
    alu_r4_r5(OP_SUB);
    chk("sub", dut.z, 64'h0000_0000_FFFF_FFFB);

    // Shifts and rotates with Y = 0x80000001, B = 1
    mdr_load(32'h8000_0001); dp.s_MDR = 1; dp.e_R4 = 1; tick();
    mdr_load(32'h1);         dp.s_MDR = 1; dp.e_R5 = 1; tick();
    alu_r4_r5(OP_SHRA); chk("shra", dut.z, 64'hC000_0000);
    alu_r4_r5(OP_ROR);  chk("ror",  dut.z, 64'hC000_0000);
    alu_r4_r5(OP_ROL);  chk("rol",  dut.z, 64'h0000_0003);
    alu_r4_r5(OP_SHR);  chk("shr",  dut.z, 64'h4000_0000);
    alu_r4_r5(OP_SHL);  chk("shl",  dut.z, 64'h0000_0002);
    alu_r4_r5(OP_ADD);  chk("add",  dut.z, 64'h8000_0002);
    alu_r4_r5(5'b11111); chk("bad_op", dut.z, 64'h0);

    // Divide by zero: Y = 0x10, bus idle (0)
    mdr_load(32'h10); dp.s_MDR = 1; dp.e_R4 = 1; tick();
    dp.s_R4 = 1; dp.e_Y = 1; tick();
    dp.opcode = OP_DIV; dp.e_alu = 1; dp.e_Z = 1; tick();
    chk("div0", dut.z, MULDIV ? 64'h0000_0010_FFFF_FFFF : 64'h0);

    // sub wrap and neg with Y = 0x10, B = R2 = 0xB7
    dp.s_R2 = 1; dp.opcode = OP_SUB; dp.e_alu = 1; dp.e_Z = 1; tick();
    chk("sub_wrap", dut.z, 64'hFFFF_FF59);
    dp.s_R2 = 1; dp.opcode = OP_NEG; dp.e_alu = 1; dp.e_Z = 1; tick();
    chk("neg", dut.z, 64'hFFFF_FF49);
    dp.s_R2 = 1; dp.opcode = OP_NOT; dp.e_alu = 1; dp.e_Z = 1; tick();
    chk("not", dut.z, 64'hFFFF_FF48);
    dp.s_R2 = 1; dp.opcode = OP_AND; dp.e_alu = 1; dp.e_Z = 1; tick();
    chk("and", dut.z, 64'h10);

    // e_alu low gives 0; IncPC overrides e_alu low
    dp.s_R2 = 1; dp.opcode = OP_ADD; dp.e_Z = 1; tick();
    chk("alu_off", dut.z, 64'h0);
    dp.s_R2 = 1; dp.opcode = OP_SUB; dp.w_IncPC = 1; dp.e_Z = 1; tick();
    chk("incpc", dut.z, 64'hB8);

    // HI load, then synchronous clear beats enables
    dp.s_R3 = 1; dp.e_HI = 1; tick();
    chk("hi", {32'b0, dut.hi}, 64'hA6);
    clr = 1; dp.e_R1 = 1; dp.s_MDR = 1; tick();
    clr = 0;
    dp.s_MDR = 1; #1; chk("clr_bus", {32'b0, dp.o_bus}, 64'h0); idle();
    chk("clr_r1", {32'b0, dut.r1}, 64'h0);
    chk("clr_regs", {32'b0, dut.r2 | dut.r3 | dut.r4 | dut.r5 | dut.pc}, 64'h0);
    chk("clr_y_hi_lo", {32'b0, dut.y | dut.hi | dut.lo | dut.mdr}, 64'h0);
    chk("clr_z", dut.z, 64'h0);
    chk("clr_ir_mar", {dp.o_IR, dp.o_MAR}, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
